// File: rtl/seq_unit_pkg.sv
// Shared opcode encoding and FSM state type for the sequential multiply/shift unit.
package seq_unit_pkg;

    localparam logic [2:0] OP_MUL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of the working register for SLL/SRL/SRA/ROR.
module shift_step
    import seq_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       op,
    input  logic             sign_bit,
    output logic [WIDTH-1:0] stepped
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        stepped = value;
        case (op)
            OP_SLL:  stepped = {value[WIDTH-2:0], 1'b0};
            OP_SRL:  stepped = {1'b0, value[WIDTH-1:1]};
            OP_SRA:  stepped = {sign_bit, value[WIDTH-1:1]};
            OP_ROR:  stepped = {value[0], value[WIDTH-1:1]};
            default: stepped = value;
        endcase
    end

endmodule

// File: rtl/seq_mul_shift_unit.sv
// Multi-cycle unsigned shift-add multiplier and bit-serial shifter with START/BUSY/DONE handshake.
module seq_mul_shift_unit
    import seq_unit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI
);

    localparam int CNT_W = SHAMT_W + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, load_cnt;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   work_q, work_d, stepped;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sign_q, sign_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   result_q, result_d, result_hi_q, result_hi_d;
    logic               busy_q, busy_d, done_q, done_d;

    shift_step #(.WIDTH(WIDTH)) u_shift_step (
        .value    (work_q),
        .op       (op_q),
        .sign_bit (sign_q),
        .stepped  (stepped)
    );

    // Multiplier lives in the low half of the accumulator and is consumed from bit 0.
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, mcand_q} & {(WIDTH+1){acc_q[0]}});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        mcand_d     = mcand_q;
        work_d      = work_q;
        acc_d       = acc_q;
        sign_d      = sign_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        load_cnt    = '0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    op_d    = OP;
                    mcand_d = DATA1;
                    work_d  = DATA1;
                    sign_d  = DATA1[WIDTH-1];
                    acc_d   = {{WIDTH{1'b0}}, DATA2};
                    case (OP)
                        OP_MUL:                         load_cnt = CNT_W'(WIDTH);
                        OP_SLL, OP_SRL, OP_SRA, OP_ROR: load_cnt = {1'b0, DATA2[SHAMT_W-1:0]};
                        default:                        load_cnt = '0;
                    endcase
                    cnt_d = load_cnt;
                    if (load_cnt == '0) begin
                        state_d     = FIN;
                        result_d    = DATA1;
                        result_hi_d = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (op_q == OP_MUL) begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end else begin
                    work_d = stepped;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIN;
                    if (op_q == OP_MUL) begin
                        {result_hi_d, result_d} = acc_d;
                    end else begin
                        result_d    = stepped;
                        result_hi_d = '0;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            mcand_q     <= '0;
            work_q      <= '0;
            acc_q       <= '0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            mcand_q     <= mcand_d;
            work_q      <= work_d;
            acc_q       <= acc_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign RESULT    = result_q;
    assign RESULT_HI = result_hi_q;

endmodule

// File: tb/tb_seq_mul_shift_unit.sv
// Bench for seq_mul_shift_unit: fixed vectors, random ops against an arithmetic model, handshake corners.
module tb_seq_mul_shift_unit;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         START;
    logic [2:0]   OP;
    logic [W-1:0] DATA1, DATA2;
    logic         BUSY, DONE;
    logic [W-1:0] RESULT, RESULT_HI;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int           n;
    } vec_t;

    vec_t vecs[14];

    seq_mul_shift_unit #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .OP        (OP),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESULT    (RESULT),
        .RESULT_HI (RESULT_HI)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference: plain arithmetic on the operation's definition.
    function automatic vec_t ref_model(input logic [2:0] op, input logic [W-1:0] d1,
                                       input logic [W-1:0] d2);
        vec_t         v;
        int           k;
        logic [2*W-1:0] wide;
        v.op = op; v.d1 = d1; v.d2 = d2;
        k = int'(d2) % W;
        v.hi = '0;
        case (op)
            3'd0: begin
                wide = {{W{1'b0}}, d1} * {{W{1'b0}}, d2};
                v.lo = wide[W-1:0]; v.hi = wide[2*W-1:W]; v.n = W;
            end
            3'd1: begin v.lo = d1 << k;            v.n = k; end
            3'd2: begin v.lo = d1 >> k;            v.n = k; end
            3'd3: begin v.lo = $signed(d1) >>> k;  v.n = k; end
            3'd4: begin wide = {d1, d1} >> k; v.lo = wide[W-1:0]; v.n = k; end
            default: begin v.lo = d1;              v.n = 0; end
        endcase
        return v;
    endfunction

    // Entered and left at the sample point just after a rising edge.
    task automatic run_vec(input string tag, input vec_t v);
        int edges;
        bit busy_ok;
        OP = v.op; DATA1 = v.d1; DATA2 = v.d2; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        OP = 3'($urandom); DATA1 = W'($urandom); DATA2 = W'($urandom);
        edges = 0; busy_ok = 1'b1;
        while (!DONE && edges < 40) begin
            if (!BUSY) busy_ok = 1'b0;
            @(posedge CLK); #1;
            edges++;
        end
        check({tag, "_latency"}, edges, v.n);
        check({tag, "_result"}, int'(RESULT), int'(v.lo));
        check({tag, "_result_hi"}, int'(RESULT_HI), int'(v.hi));
        check({tag, "_busy_run"}, int'(busy_ok & BUSY), 1);
        @(posedge CLK); #1;
        check({tag, "_done_pulse"}, int'(DONE), 0);
        check({tag, "_busy_fall"}, int'(BUSY), 0);
    endtask

    initial begin
        int   edges;
        bit   seen_done;
        vec_t v;

        vecs[0]  = '{3'd0, 8'h03, 8'h05, 8'h0F, 8'h00, 8};
        vecs[1]  = '{3'd0, 8'd200, 8'd100, 8'h20, 8'h4E, 8};
        vecs[2]  = '{3'd0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 8};
        vecs[3]  = '{3'd3, 8'h90, 8'h02, 8'hE4, 8'h00, 2};
        vecs[4]  = '{3'd2, 8'h90, 8'h02, 8'h24, 8'h00, 2};
        vecs[5]  = '{3'd1, 8'h81, 8'h01, 8'h02, 8'h00, 1};
        vecs[6]  = '{3'd4, 8'h81, 8'h01, 8'hC0, 8'h00, 1};
        vecs[7]  = '{3'd1, 8'h5A, 8'h00, 8'h5A, 8'h00, 0};
        vecs[8]  = '{3'd2, 8'h5A, 8'h08, 8'h5A, 8'h00, 0};
        vecs[9]  = '{3'd5, 8'h3C, 8'h77, 8'h3C, 8'h00, 0};
        vecs[10] = '{3'd4, 8'h01, 8'h07, 8'h02, 8'h00, 7};
        vecs[11] = '{3'd3, 8'h80, 8'hF7, 8'hFF, 8'h00, 7};
        vecs[12] = '{3'd0, 8'h00, 8'hAB, 8'h00, 8'h00, 8};
        vecs[13] = '{3'd7, 8'hC3, 8'h01, 8'hC3, 8'h00, 0};

        RESET = 1'b1; START = 1'b0; OP = '0; DATA1 = '0; DATA2 = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", int'(BUSY), 0);
        check("reset_done", int'(DONE), 0);
        check("reset_result", int'(RESULT), 0);
        check("reset_result_hi", int'(RESULT_HI), 0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 40; i++) begin
            v = ref_model(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            run_vec($sformatf("rand%0d_op%0d", i, v.op), v);
        end

        // START during RUN is ignored; next START only lands in the first IDLE cycle.
        OP = 3'd0; DATA1 = 8'd7; DATA2 = 8'd9; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        OP = 3'd1; DATA1 = 8'hFF; DATA2 = 8'h01; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        edges = 4;
        while (!DONE && edges < 40) begin
            @(posedge CLK); #1;
            edges++;
        end
        check("busy_start_latency", edges, 8);
        check("busy_start_result", int'(RESULT), 8'h3F);
        check("busy_start_result_hi", int'(RESULT_HI), 0);
        OP = 3'd5; DATA1 = 8'h11; DATA2 = 8'h00; START = 1'b1;
        @(posedge CLK); #1;
        check("fin_start_ignored_busy", int'(BUSY), 0);
        check("fin_start_ignored_done", int'(DONE), 0);
        check("result_held_in_idle", int'(RESULT), 8'h3F);
        @(posedge CLK); #1;
        START = 1'b0;
        check("first_idle_accept_done", int'(DONE), 1);
        check("first_idle_accept_result", int'(RESULT), 8'h11);
        @(posedge CLK); #1;
        check("first_idle_done_fall", int'(DONE), 0);

        // Asynchronous reset in the middle of a multiply.
        OP = 3'd0; DATA1 = 8'hFF; DATA2 = 8'hFF; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        check("midrst_busy", int'(BUSY), 0);
        check("midrst_done", int'(DONE), 0);
        check("midrst_result", int'(RESULT), 0);
        check("midrst_result_hi", int'(RESULT_HI), 0);
        #2;
        RESET = 1'b0;
        seen_done = 1'b0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) seen_done = 1'b1;
        end
        check("midrst_no_done", int'(seen_done), 0);
        run_vec("post_reset_mul", '{3'd0, 8'd7, 8'd6, 8'h2A, 8'h00, 8});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
